// File: rtl/exec_pkg.sv
// Shared definitions for the execution-element sequencer: FSM states,
// branch/jump instruction numbers and the architectural PC increment.
package exec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } seq_state_e;

  localparam logic [5:0] INST_BEQ  = 6'd32;
  localparam logic [5:0] INST_BNE  = 6'd33;
  localparam logic [5:0] INST_BLT  = 6'd34;
  localparam logic [5:0] INST_BGE  = 6'd35;
  localparam logic [5:0] INST_BLTU = 6'd36;
  localparam logic [5:0] INST_BGEU = 6'd37;
  localparam logic [5:0] INST_BLEZ = 6'd38;
  localparam logic [5:0] INST_J    = 6'd39;
  localparam logic [5:0] INST_JAL  = 6'd40;
  localparam logic [5:0] INST_JR   = 6'd41;
  localparam logic [5:0] INST_JALR = 6'd42;

  // Sequential fall-through address; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] cur_pc);
    return cur_pc + 32'd4;
  endfunction

endpackage

// File: rtl/exec_element_sequencer.sv
// Hands one decoded instruction at a time to an external execution element,
// waits (bounded) for it to finish, then commits the new PC and writeback.
module exec_element_sequencer
  import exec_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [5:0]  inst_num,
  input  logic [31:0] const16_x,
  input  logic [25:0] addr26,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [4:0]  dest_reg,
  input  logic        wb_en,
  output logic [31:0] pc,
  output logic        elem_reset,
  output logic [5:0]  elem_inst_num,
  output logic [31:0] elem_const16_x,
  output logic [25:0] elem_addr26,
  output logic [31:0] elem_rs,
  output logic [31:0] elem_rt,
  input  logic        elem_completed,
  input  logic [31:0] elem_reg_out,
  input  logic [31:0] elem_pc_out,
  output logic        gpr_we,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  output logic        timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // The abort fires on the edge that would take the count to TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_e       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [4:0]       dest_q;
  logic             wb_en_q;

  assign inst_ready = (state == IDLE);
  assign elem_reset = (state == IDLE) || (state == START);

  // NOTE: every register here updates with <= so all of them sample the
  // pre-edge values of each other; blocking writes would chain within a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the latched operand copies are plain flops, not a memory, so
      // they are cleared here along with the control state.
      state          <= IDLE;
      pc             <= RESET_PC;
      wait_cnt       <= '0;
      dest_q         <= '0;
      wb_en_q        <= 1'b0;
      elem_inst_num  <= '0;
      elem_const16_x <= '0;
      elem_addr26    <= '0;
      elem_rs        <= '0;
      elem_rt        <= '0;
      gpr_we         <= 1'b0;
      gpr_waddr      <= '0;
      gpr_wdata      <= '0;
      timeout_err    <= 1'b0;
    end else begin
      gpr_we <= 1'b0;
      case (state)
        IDLE: begin
          if (inst_valid) begin
            elem_inst_num  <= inst_num;
            elem_const16_x <= const16_x;
            elem_addr26    <= addr26;
            elem_rs        <= rs_val;
            elem_rt        <= rt_val;
            dest_q         <= dest_reg;
            wb_en_q        <= wb_en;
            state          <= START;
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          // Completion takes priority over a coincident timeout.
          if (elem_completed) begin
            pc        <= elem_pc_out;
            gpr_wdata <= elem_reg_out;
            gpr_waddr <= dest_q;
            gpr_we    <= wb_en_q && (dest_q != 5'd0);
            state     <= WB;
          end else if (wait_cnt == CNT_LAST) begin
            pc          <= pc_plus4(pc);
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        WB: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_element_sequencer.sv
// Directed bench: a stub execution element with programmable latency, a
// transaction-level expectation model and a per-cycle output comparison.
module tb_exec_element_sequencer;

  localparam int          TMO  = 4;
  localparam logic [31:0] RPC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [5:0]  inst_num = '0;
  logic [31:0] const16_x = '0;
  logic [25:0] addr26 = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic [4:0]  dest_reg = '0;
  logic        wb_en = 1'b0;
  logic [31:0] pc;
  logic        elem_reset;
  logic [5:0]  elem_inst_num;
  logic [31:0] elem_const16_x;
  logic [25:0] elem_addr26;
  logic [31:0] elem_rs;
  logic [31:0] elem_rt;
  logic        elem_completed = 1'b0;
  logic [31:0] elem_reg_out = '0;
  logic [31:0] elem_pc_out = '0;
  logic        gpr_we;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        timeout_err;

  exec_element_sequencer #(.TIMEOUT_CYCLES(TMO), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(rst),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_num(inst_num), .const16_x(const16_x), .addr26(addr26),
    .rs_val(rs_val), .rt_val(rt_val), .dest_reg(dest_reg), .wb_en(wb_en),
    .pc(pc), .elem_reset(elem_reset),
    .elem_inst_num(elem_inst_num), .elem_const16_x(elem_const16_x),
    .elem_addr26(elem_addr26), .elem_rs(elem_rs), .elem_rt(elem_rt),
    .elem_completed(elem_completed), .elem_reg_out(elem_reg_out),
    .elem_pc_out(elem_pc_out),
    .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural effect of each instruction: {next_pc, result}.
  function automatic logic [63:0] sem(input logic [5:0] n, input logic [31:0] c16,
                                      input logic [25:0] a26, input logic [31:0] rs,
                                      input logic [31:0] rt, input logic [31:0] cur);
    logic [31:0] npc;
    logic [31:0] res;
    npc = cur + 32'd4;
    res = rs + rt;
    case (n)
      6'd32: if (rs == rt) npc = cur + (c16 << 2);
      6'd33: if (rs != rt) npc = cur + (c16 << 2);
      6'd39: npc = {cur[31:28], a26, 2'b00};
      6'd40: begin npc = {cur[31:28], a26, 2'b00}; res = cur + 32'd4; end
      6'd41: npc = rs;
      6'd42: begin npc = rs; res = cur + 32'd4; end
      default: ;
    endcase
    return {npc, res};
  endfunction

  // Stub element: completes stub_lat cycles after release, never if 0.
  int stub_lat = 1;
  int stub_cnt = 0;
  always @(posedge clk) begin
    if (elem_reset) begin
      stub_cnt       <= 0;
      elem_completed <= 1'b0;
    end else if (!elem_completed) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_lat != 0 && stub_cnt + 1 == stub_lat) begin
        elem_completed <= 1'b1;
        {elem_pc_out, elem_reg_out} <= sem(elem_inst_num, elem_const16_x, elem_addr26,
                                           elem_rs, elem_rt, pc);
      end
    end
  end

  // Writeback monitor for the literal checks.
  int          we_count = 0;
  logic [4:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;
  always @(negedge clk) begin
    if (!rst && gpr_we) begin
      we_count   <= we_count + 1;
      last_waddr <= gpr_waddr;
      last_wdata <= gpr_wdata;
    end
  end

  // Transaction model: an accepted instruction occupies the sequencer until
  // edge m_end after acceptance (completion at latency+2, timeout at TMO+1).
  logic        m_busy, m_wb, m_we, m_err, m_wben, m_done_ok;
  int          m_age, m_end;
  logic [31:0] m_pc, m_npc, m_res, m_c16, m_rs, m_rt, m_wdata;
  logic [5:0]  m_inst;
  logic [25:0] m_a26;
  logic [4:0]  m_dest, m_waddr;

  task automatic model_reset();
    m_busy = 0; m_wb = 0; m_we = 0; m_err = 0; m_wben = 0; m_done_ok = 0;
    m_age = 0; m_end = 0; m_pc = RPC; m_npc = '0; m_res = '0;
    m_c16 = '0; m_rs = '0; m_rt = '0; m_inst = '0; m_a26 = '0; m_dest = '0;
    m_waddr = '0; m_wdata = '0;
  endtask

  task automatic model_step();
    m_we = 0;
    if (!m_busy) begin
      if (inst_valid) begin
        m_busy = 1; m_age = 0; m_wb = 0;
        m_inst = inst_num; m_c16 = const16_x; m_a26 = addr26;
        m_rs = rs_val; m_rt = rt_val; m_dest = dest_reg; m_wben = wb_en;
        {m_npc, m_res} = sem(m_inst, m_c16, m_a26, m_rs, m_rt, m_pc);
        m_done_ok = (stub_lat != 0) && (stub_lat <= TMO - 1);
        m_end = m_done_ok ? stub_lat + 2 : TMO + 1;
      end
    end else if (m_wb) begin
      m_wb = 0; m_busy = 0; m_age = 0;
    end else begin
      m_age++;
      if (m_age == m_end) begin
        if (m_done_ok) begin
          m_pc = m_npc; m_waddr = m_dest; m_wdata = m_res;
          m_we = m_wben && (m_dest != 5'd0);
          m_wb = 1;
        end else begin
          m_pc = m_pc + 32'd4; m_err = 1; m_busy = 0; m_age = 0;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("inst_ready", 32'(inst_ready), 32'(!m_busy));
        check("elem_reset", 32'(elem_reset), 32'(!m_busy || m_age == 0));
        check("pc", pc, m_pc);
        check("gpr_we", 32'(gpr_we), 32'(m_we));
        check("gpr_waddr", 32'(gpr_waddr), 32'(m_waddr));
        check("gpr_wdata", gpr_wdata, m_wdata);
        check("timeout_err", 32'(timeout_err), 32'(m_err));
        check("elem_inst_num", 32'(elem_inst_num), 32'(m_inst));
        check("elem_const16_x", elem_const16_x, m_c16);
        check("elem_addr26", 32'(elem_addr26), 32'(m_a26));
        check("elem_rs", elem_rs, m_rs);
        check("elem_rt", elem_rt, m_rt);
      end
    end
  end

  task automatic issue(input logic [5:0] n, input logic [31:0] c16, input logic [25:0] a26,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] d,
                       input logic w, input int lat, output int busy);
    logic accepted;
    logic done;
    @(posedge clk); #2;
    stub_lat = lat; inst_num = n; const16_x = c16; addr26 = a26;
    rs_val = rs; rt_val = rt; dest_reg = d; wb_en = w; inst_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (inst_ready) accepted = 1'b1;
    end
    @(posedge clk); #2;
    inst_valid = 1'b0;
    check("accept_seen", 32'(accepted), 32'd1);
    busy = 0;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (inst_ready) done = 1'b1;
      else busy++;
    end
    check("return_to_idle", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy;
    int we0;
    int n;
    int last;
    logic [25:0] tgt [3];
    tgt[0] = 26'h10; tgt[1] = 26'h20; tgt[2] = 26'h30;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_ready", 32'(inst_ready), 32'd1);
    check("rst_elem_reset", 32'(elem_reset), 32'd1);
    check("rst_gpr_we", 32'(gpr_we), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    check("rst_wdata", gpr_wdata, 32'h0);
    @(posedge clk); #2 rst = 1'b0;

    // JAL to 0x400 from pc 0, link r31.
    issue(6'd40, 32'h0, 26'h0000100, 32'h0, 32'h0, 5'd31, 1'b1, 1, busy);
    check("jal_latency", 32'(busy), 32'd4);
    check("jal_pc", pc, 32'h0000_0400);
    check("jal_we_count", 32'(we_count), 32'd1);
    check("jal_waddr", 32'(last_waddr), 32'd31);
    check("jal_wdata", last_wdata, 32'd4);

    // JR to 0x100, then BEQ taken with offset 3 words.
    issue(6'd41, 32'h0, 26'h0, 32'h100, 32'h0, 5'd5, 1'b0, 1, busy);
    check("jr_pc", pc, 32'h100);
    issue(6'd32, 32'd3, 26'h0, 32'd5, 32'd5, 5'd0, 1'b0, 1, busy);
    check("beq_pc", pc, 32'h10C);
    check("beq_latency", 32'(busy), 32'd4);
    check("beq_no_we", 32'(we_count), 32'd1);
    check("beq_const_held", elem_const16_x, 32'd3);

    // Ordinary writeback to r7.
    issue(6'd2, 32'h0, 26'h0, 32'h11, 32'h22, 5'd7, 1'b1, 1, busy);
    check("alu_pc", pc, 32'h110);
    check("alu_waddr", 32'(last_waddr), 32'd7);
    check("alu_wdata", last_wdata, 32'h33);

    // JALR with r0 destination: jump taken, write suppressed.
    issue(6'd42, 32'h0, 26'h0, 32'h2000, 32'h0, 5'd0, 1'b1, 1, busy);
    check("jalr_pc", pc, 32'h2000);
    check("jalr_no_we", 32'(we_count), 32'd2);

    // Completion on the same edge as the timeout: completion wins.
    issue(6'd41, 32'h0, 26'h0, 32'h40, 32'h0, 5'd0, 1'b0, TMO - 1, busy);
    check("race_latency", 32'(busy), 32'd6);
    check("race_pc", pc, 32'h40);
    check("race_err", 32'(timeout_err), 32'd0);

    // Element never completes: abort after TMO wait cycles.
    issue(6'd40, 32'h0, 26'h3FF, 32'h0, 32'h0, 5'd9, 1'b1, 0, busy);
    check("tmo_latency", 32'(busy), 32'd5);
    check("tmo_pc", pc, 32'h44);
    check("tmo_err", 32'(timeout_err), 32'd1);
    check("tmo_no_we", 32'(we_count), 32'd2);

    // pc+4 wraps at the top of the address space.
    issue(6'd41, 32'h0, 26'h0, 32'hFFFF_FFFC, 32'h0, 5'd0, 1'b0, 1, busy);
    check("wrap_setup_pc", pc, 32'hFFFF_FFFC);
    issue(6'd41, 32'h0, 26'h0, 32'h1234, 32'h0, 5'd0, 1'b0, 0, busy);
    check("wrap_pc", pc, 32'h0);
    check("wrap_err_sticky", 32'(timeout_err), 32'd1);

    // Reset while waiting on the element.
    issue(6'd41, 32'h0, 26'h0, 32'h500, 32'h0, 5'd0, 1'b0, 1, busy);
    check("pre_rst_pc", pc, 32'h500);
    @(posedge clk); #2;
    stub_lat = 0; inst_num = 6'd42; rs_val = 32'h700; dest_reg = 5'd3; wb_en = 1'b1;
    inst_valid = 1'b1;
    @(posedge clk); #2 inst_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_pc", pc, RPC);
    check("midrst_ready", 32'(inst_ready), 32'd1);
    check("midrst_elem_reset", 32'(elem_reset), 32'd1);
    check("midrst_gpr_we", 32'(gpr_we), 32'd0);
    check("midrst_err", 32'(timeout_err), 32'd0);
    check("midrst_elem_rs", elem_rs, 32'h0);
    we0 = we_count;
    @(posedge clk); #2 rst = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_no_write", 32'(we_count - we0), 32'd0);
    check("midrst_pc_hold", pc, RPC);

    // inst_valid held high across three JALs.
    @(posedge clk); #2;
    stub_lat = 1; inst_num = 6'd40; const16_x = '0; rs_val = '0; rt_val = '0;
    dest_reg = 5'd31; wb_en = 1'b1; addr26 = tgt[0]; inst_valid = 1'b1;
    we0 = we_count;
    n = 0;
    last = 0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      @(negedge clk);
      if (inst_ready) begin
        if (n > 0) check("stream_gap", 32'(c - last), 32'd5);
        last = c;
        n++;
        @(posedge clk); #2;
        if (n < 3) addr26 = tgt[n];
        else inst_valid = 1'b0;
      end
    end
    check("stream_accepts", 32'(n), 32'd3);
    for (int i = 0; i < 20 && !inst_ready; i++) @(negedge clk);
    @(negedge clk);
    check("stream_pc", pc, 32'h0000_00C0);
    check("stream_writes", 32'(we_count - we0), 32'd3);
    check("stream_last_wdata", last_wdata, 32'h84);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_element_sequencer.md
EXEC_ELEMENT_SEQUENCER -- requirements
Module: exec_element_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum WAIT cycles before abort.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: pc value after reset.
REQ-003 clk  in  1  single clock; all state on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 inst_valid  in  1  decoded instruction offered.
REQ-006 inst_ready  out  1  sequencer can accept; high only in IDLE.
REQ-007 inst_num  in  6  instruction number (branch/jump group 32..42).
REQ-008 const16_x  in  32  sign-extended immediate.
REQ-009 addr26  in  26  jump target field.
REQ-010 rs_val, rt_val  in  32 each  source operand values.
REQ-011 dest_reg  in  5  writeback register index.
REQ-012 wb_en  in  1  instruction writes reg_out back.
REQ-013 pc  out  32  architectural PC owned by this block.
REQ-014 elem_reset  out  1  synchronous reset/start to the exec element.
REQ-015 elem_inst_num, elem_const16_x, elem_addr26, elem_rs, elem_rt  out  6/32/26/32/32  latched operands to the element.
REQ-016 elem_completed  in  1  element done flag.
REQ-017 elem_reg_out, elem_pc_out  in  32 each  element results.
REQ-018 gpr_we  out  1  one-cycle register write strobe.
REQ-019 gpr_waddr, gpr_wdata  out  5/32  write address/data.
REQ-020 timeout_err  out  1  sticky abort flag.

Function
REQ-021 FSM states SHALL be IDLE, START, WAIT, WB.
REQ-022 IDLE: elem_reset=1, inst_ready=1; inst_valid&inst_ready at an edge latches all operands, dest_reg, wb_en, goes to START.
REQ-023 START: elem_reset=1 for exactly one cycle; next state WAIT; timeout counter cleared to 0.
REQ-024 WAIT: elem_reset=0; counter increments each cycle; elem_completed=1 -> WB, same edge registers pc<=elem_pc_out, gpr_wdata<=elem_reg_out, gpr_waddr<=dest_reg.
REQ-025 gpr_we SHALL be 1 during WB only if wb_en latched =1 and dest_reg!=0; else 0.
REQ-026 WB lasts one cycle, then IDLE; elem_* operand outputs hold latched values from accept until next accept.
REQ-027 Latency: accept edge E0, START->WAIT at E1, 1-cycle element completes at E2, WB entered at E3, IDLE at E4; inst_ready high from E4.
REQ-028 Timeout: counter reaching TIMEOUT_CYCLES while elem_completed=0 -> IDLE, pc<=pc+4 (mod 2^32), no gpr_we, timeout_err<=1 (sticky until reset).
REQ-029 elem_completed and timeout on same cycle: completion wins, normal WB, timeout_err unchanged.
REQ-030 inst_valid outside IDLE SHALL be ignored; offered instruction not consumed.
REQ-031 pc+4 and elem_pc_out SHALL be 32-bit wrapping; 32'hFFFF_FFFC+4 = 0.

Reset
REQ-032 Asynchronous reset SHALL set state=IDLE, pc=RESET_PC, gpr_we=0, gpr_waddr=0, gpr_wdata=0, timeout_err=0, counter=0, latched operands=0; elem_reset=1, inst_ready=1 follow IDLE.
REQ-033 Reset mid-operation (any state) SHALL abort with no write and no pc update beyond RESET_PC.

Structure
REQ-034 Shared package exec_pkg SHALL hold the state enum and instruction-number constants BEQ=32..JALR=42.
REQ-035 No sub-module; the exec element is instantiated beside this block, not inside it.

Verification
REQ-036 JAL inst_num=40, addr26=26'h0000100, pc=0, dest_reg=31, wb_en=1 -> at E3 pc=32'h0000_0400, WB gpr_we=1, waddr=31, wdata=4.
REQ-037 BEQ rs=rt=5, const16_x=3, pc=0x100, wb_en=0 -> pc=0x10C, gpr_we stays 0; inst_ready high at E4.
REQ-038 JALR rs=0x2000, dest_reg=0, wb_en=1 -> pc=0x2000, gpr_we=0 (r0 suppressed).
REQ-039 Stub element never completes, TIMEOUT_CYCLES=4, pc=0x40 -> IDLE after 4 WAIT cycles, pc=0x44, timeout_err=1, no gpr_we.
REQ-040 reset asserted during WAIT -> same-cycle pc=RESET_PC, state IDLE, gpr_we=0, no later write.
REQ-041 inst_valid held high continuously, three JALs -> exactly three accepts, one per 5-cycle interval, pc sequence matches each target.
